// File: rtl/mem_bus_arbiter_if.sv
// Purpose: cache-side request/ready signals and main-memory port shared by the
//          i-cache, the d-cache and mem_bus_arbiter.
// Latency: wiring only, no state.
// Backpressure: none here. The arbiter holds each requester with its ready.
// Ports: slave  = arbiter view (drives readies, memory request, gnt, bus_err)
//        master = cache/memory-model view (drives requests, addresses, mem_ready)
interface mem_bus_arbiter_if;
  logic        i_access;
  logic [31:0] i_a;
  logic        i_ready;
  logic        d_access;
  logic        d_write;
  logic [31:0] d_a;
  logic [31:0] d_st_data;
  logic        d_ready;
  logic        mem_ready;
  logic        mem_access;
  logic        mem_write;
  logic [31:0] mem_a;
  logic [31:0] mem_st_data;
  logic [1:0]  gnt;
  logic        bus_err;

  modport slave (
    input  i_access, i_a, d_access, d_write, d_a, d_st_data, mem_ready,
    output i_ready, d_ready, mem_access, mem_write, mem_a, mem_st_data, gnt, bus_err
  );

  modport master (
    output i_access, i_a, d_access, d_write, d_a, d_st_data, mem_ready,
    input  i_ready, d_ready, mem_access, mem_write, mem_a, mem_st_data, gnt, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: registered, transaction-locked arbiter between i-cache and d-cache on one memory port.
// Latency: a request seen in IDLE is granted at the next edge. Ready is combinational from mem_ready.
// Backpressure: the requester waits while its ready is low. The grant is held until mem_ready, abort or watchdog.
// Ports: clk, rst (async, active-high), bus (mem_bus_arbiter_if.slave).
// Params: STARVE_LIMIT (1..15) sets how many consecutive contested I grants are allowed before D wins.
//         WDOG_CYCLES (1..255) sets the watchdog timeout in grant cycles.
// Option: define MEM_ARB_WDOG_EN to enable the bus watchdog. Otherwise bus_err is tied 0.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned WDOG_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  // The state encoding is the gnt output encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       granted_access;
  logic       timeout;

  assign granted_access = ((state_q == GNT_I) && bus.i_access) ||
                          ((state_q == GNT_D) && bus.d_access);

`ifdef MEM_ARB_WDOG_EN
  logic [7:0] wdog_cnt_q, wdog_cnt_d;

  // Every grant is entered from IDLE, so clearing the counter in IDLE clears it on grant entry.
  // The timeout fires in the cycle in which the count would reach WDOG_CYCLES.
  // An aborted request exits through the abort path and never times out.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    timeout    = 1'b0;
    if (state_q == IDLE) begin
      wdog_cnt_d = 8'd0;
    end else if (granted_access && !bus.mem_ready) begin
      wdog_cnt_d = wdog_cnt_q + 8'd1;
      if (({1'b0, wdog_cnt_q} + 9'd1) == 9'(WDOG_CYCLES)) begin
        timeout = 1'b1;
      end
    end
  end
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES == 0);
  assign timeout         = 1'b0;
`endif

  // Next-state and starvation bookkeeping
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_access && bus.d_access) begin
          if (starve_cnt_q == 4'(STARVE_LIMIT)) begin
            state_d      = GNT_D;
            starve_cnt_d = 4'd0;
          end else begin
            state_d      = GNT_I;
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (bus.i_access) begin
          state_d = GNT_I;
        end else if (bus.d_access) begin
          state_d      = GNT_D;
          starve_cnt_d = 4'd0;
        end
      end
      GNT_I: begin
        if (!bus.i_access || bus.mem_ready || timeout) state_d = IDLE;
      end
      GNT_D: begin
        if (!bus.d_access || bus.mem_ready || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus mux follows the registered grant only. An asynchronous reset forces IDLE,
  // so every output drops to 0 at once.
  always_comb begin
    bus.mem_access  = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_a       = 32'd0;
    bus.mem_st_data = 32'd0;
    bus.i_ready     = 1'b0;
    bus.d_ready     = 1'b0;
    case (state_q)
      GNT_I: begin
        bus.mem_access = bus.i_access;
        bus.mem_a      = bus.i_a;
        bus.i_ready    = bus.mem_ready || timeout;
      end
      GNT_D: begin
        bus.mem_access  = bus.d_access;
        bus.mem_write   = bus.d_write;
        bus.mem_a       = bus.d_a;
        bus.mem_st_data = bus.d_st_data;
        bus.d_ready     = bus.mem_ready || timeout;
      end
      default: ;
    endcase
  end

  assign bus.gnt     = state_q;
  assign bus.bus_err = timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
`ifdef MEM_ARB_WDOG_EN
      wdog_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef MEM_ARB_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.STARVE_LIMIT(4), .WDOG_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge. Outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_access  = 1'b0;
    bus.i_a       = 32'd0;
    bus.d_access  = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_a       = 32'd0;
    bus.d_st_data = 32'd0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.i_access = 1'b1;
    bus.d_access = 1'b1;
    bus.i_a = 32'h0000_0100;
    bus.d_a = 32'h0000_0200;
    bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    tests_run++; if (bus.gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    tests_run++; if ({bus.mem_access, bus.mem_write, bus.i_ready, bus.d_ready, bus.bus_err} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctl got=%b exp=00000", {bus.mem_access, bus.mem_write, bus.i_ready, bus.d_ready, bus.bus_err}); end
    tests_run++; if ({bus.mem_a, bus.mem_st_data} !== 64'd0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", {bus.mem_a, bus.mem_st_data}); end
    bus.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); #1;
    tests_run++; if (bus.gnt !== 2'b01) begin tests_failed++; $display("FAIL post_reset_gnt got=%b exp=01", bus.gnt); end
    tests_run++; if (bus.mem_a !== 32'h0000_0100) begin tests_failed++; $display("FAIL post_reset_mem_a got=%h exp=00000100", bus.mem_a); end
    // Reset in the middle of a grant must clear everything at once, before the next edge.
    rst = 1'b1;
    #1;
    tests_run++; if ({bus.gnt, bus.mem_access} !== 3'b000) begin tests_failed++; $display("FAIL async_reset got=%b exp=000", {bus.gnt, bus.mem_access}); end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_d_store();
    apply_reset();
    bus.d_access = 1'b1;
    bus.d_write = 1'b1;
    bus.d_a = 32'h0000_1000;
    bus.d_st_data = 32'hDEAD_BEEF;
    #1;
    tests_run++; if ({bus.gnt, bus.mem_access} !== 3'b000) begin tests_failed++; $display("FAIL store_idle got=%b exp=000", {bus.gnt, bus.mem_access}); end
    tick(); #1;
    tests_run++; if (bus.gnt !== 2'b10) begin tests_failed++; $display("FAIL store_gnt got=%b exp=10", bus.gnt); end
    tests_run++; if ({bus.mem_access, bus.mem_write, bus.d_ready} !== 3'b110) begin tests_failed++; $display("FAIL store_ctl got=%b exp=110", {bus.mem_access, bus.mem_write, bus.d_ready}); end
    tests_run++; if ({bus.mem_a, bus.mem_st_data} !== {32'h0000_1000, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL store_bus got=%h exp=00001000deadbeef", {bus.mem_a, bus.mem_st_data}); end
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.d_ready} !== 3'b100) begin tests_failed++; $display("FAIL store_wait got=%b exp=100", {bus.gnt, bus.d_ready}); end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    tests_run++; if ({bus.d_ready, bus.i_ready} !== 2'b10) begin tests_failed++; $display("FAIL store_ready got=%b exp=10", {bus.d_ready, bus.i_ready}); end
    tick();
    bus.mem_ready = 1'b0;
    bus.d_access = 1'b0;
    #1;
    tests_run++; if ({bus.gnt, bus.d_ready, bus.mem_access} !== 4'b0000) begin tests_failed++; $display("FAIL store_done got=%b exp=0000", {bus.gnt, bus.d_ready, bus.mem_access}); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_gnt [10];
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    apply_reset();
    bus.i_access = 1'b1;
    bus.i_a = 32'h0000_00A0;
    bus.d_access = 1'b1;
    bus.d_a = 32'h0000_00D0;
    for (int g = 0; g < 10; g++) begin
      tick(); #1;
      tests_run++; if (bus.gnt !== exp_gnt[g]) begin tests_failed++; $display("FAIL starve_gnt[%0d] got=%b exp=%b", g, bus.gnt, exp_gnt[g]); end
      tests_run++; if (bus.mem_a !== ((exp_gnt[g] == 2'b10) ? 32'h0000_00D0 : 32'h0000_00A0)) begin
        tests_failed++; $display("FAIL starve_mem_a[%0d] got=%h", g, bus.mem_a); end
      tick();
      bus.mem_ready = 1'b1;
      #1;
      tests_run++; if ({bus.i_ready, bus.d_ready} !== ((exp_gnt[g] == 2'b10) ? 2'b01 : 2'b10)) begin
        tests_failed++; $display("FAIL starve_ready[%0d] got=%b", g, {bus.i_ready, bus.d_ready}); end
      tick();
      bus.mem_ready = 1'b0;
      #1;
      tests_run++; if (bus.gnt !== 2'b00) begin tests_failed++; $display("FAIL starve_idle[%0d] got=%b exp=00", g, bus.gnt); end
    end
    clear_inputs();
  endtask

  task automatic test_grant_lock();
    apply_reset();
    bus.d_access = 1'b1;
    bus.d_a = 32'h0000_2000;
    bus.i_a = 32'h0000_3000;
    tick(); #1;
    tests_run++; if (bus.gnt !== 2'b10) begin tests_failed++; $display("FAIL lock_first got=%b exp=10", bus.gnt); end
    bus.i_access = 1'b1;
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.i_ready} !== 3'b100) begin tests_failed++; $display("FAIL lock_hold1 got=%b exp=100", {bus.gnt, bus.i_ready}); end
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.mem_a} !== {2'b10, 32'h0000_2000}) begin tests_failed++; $display("FAIL lock_hold2 got=%h", {bus.gnt, bus.mem_a}); end
    bus.mem_ready = 1'b1;
    #1;
    tests_run++; if ({bus.d_ready, bus.i_ready} !== 2'b10) begin tests_failed++; $display("FAIL lock_ready got=%b exp=10", {bus.d_ready, bus.i_ready}); end
    tick();
    bus.mem_ready = 1'b0;
    bus.d_access = 1'b0;
    #1;
    tests_run++; if (bus.gnt !== 2'b00) begin tests_failed++; $display("FAIL lock_idle got=%b exp=00", bus.gnt); end
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.mem_a} !== {2'b01, 32'h0000_3000}) begin tests_failed++; $display("FAIL lock_next got=%h", {bus.gnt, bus.mem_a}); end
    clear_inputs();
  endtask

  task automatic test_abort();
    apply_reset();
    bus.i_access = 1'b1;
    bus.i_a = 32'h0000_4000;
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.mem_access} !== 3'b011) begin tests_failed++; $display("FAIL abort_gnt got=%b exp=011", {bus.gnt, bus.mem_access}); end
    tick();
    bus.i_access = 1'b0;
    #1;
    tests_run++; if ({bus.mem_access, bus.i_ready} !== 2'b00) begin tests_failed++; $display("FAIL abort_drop got=%b exp=00", {bus.mem_access, bus.i_ready}); end
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.i_ready, bus.mem_access} !== 4'b0000) begin tests_failed++; $display("FAIL abort_idle got=%b exp=0000", {bus.gnt, bus.i_ready, bus.mem_access}); end
    // mem_ready while idle must have no effect.
    bus.mem_ready = 1'b1;
    #1;
    tests_run++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin tests_failed++; $display("FAIL idle_ready got=%b exp=00", {bus.i_ready, bus.d_ready}); end
    tick(); #1;
    tests_run++; if (bus.gnt !== 2'b00) begin tests_failed++; $display("FAIL idle_ready_gnt got=%b exp=00", bus.gnt); end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    apply_reset();
    bus.i_access = 1'b1;
    bus.i_a = 32'h0000_5000;
`ifdef MEM_ARB_WDOG_EN
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      tests_run++; if ({bus.gnt, bus.bus_err, bus.i_ready} !== ((c == 8) ? 4'b0111 : 4'b0100)) begin
        tests_failed++; $display("FAIL wdog_cycle[%0d] got=%b", c, {bus.gnt, bus.bus_err, bus.i_ready}); end
    end
    tick(); #1;
    tests_run++; if ({bus.gnt, bus.bus_err} !== 3'b000) begin tests_failed++; $display("FAIL wdog_idle got=%b exp=000", {bus.gnt, bus.bus_err}); end
`else
    for (int c = 1; c <= 20; c++) begin
      tick(); #1;
      tests_run++; if ({bus.gnt, bus.bus_err, bus.i_ready} !== 4'b0100) begin
        tests_failed++; $display("FAIL hold_cycle[%0d] got=%b exp=0100", c, {bus.gnt, bus.bus_err, bus.i_ready}); end
    end
`endif
    clear_inputs();
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_d_store();
    test_starvation();
    test_grant_lock();
    test_abort();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
